// File: rtl/ysyx_22050710_ifu_pkg.sv
// ysyx_22050710_ifu_pkg: shared widths, reset PC, fetch FSM states and buffer entry type
package ysyx_22050710_ifu_pkg;
  localparam int XLEN = 64;
  localparam int INST_W = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h8000_0000;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DISCARD = 2'd3} pf_state_e;
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
  } inst_ent_t;
endpackage

// File: rtl/ysyx_22050710_ifu_fifo.sv
// ysyx_22050710_ifu_fifo: first-word-fall-through instruction buffer, 0/1/2 pushes and one pop per cycle
module ysyx_22050710_ifu_fifo
  import ysyx_22050710_ifu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic [1:0] push_n,
  input  inst_ent_t  push_d0,
  input  inst_ent_t  push_d1,
  input  logic       pop,
  output logic       valid,
  output inst_ent_t  head,
  output logic [AW:0] count
);
  inst_ent_t mem_q [DEPTH];
  inst_ent_t mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push_n != 2'd0) mem_d[wr_q] = push_d0;
    if (push_n == 2'd2) mem_d[AW'(wr_q + 1'b1)] = push_d1;
    wr_d = flush ? '0 : wr_q + AW'(push_n);
    rd_d = flush ? '0 : rd_q + AW'(pop);
    count_d = flush ? '0 : count_q + (AW+1)'(push_n) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk) mem_q <= mem_d;
  // Head reads as zero while empty so the outputs are clean during and after reset
  assign valid = count_q != '0;
  assign head = valid ? mem_q[rd_q] : '0;
  assign count = count_q;
endmodule

// File: rtl/ysyx_22050710_ifu_pf.sv
// ysyx_22050710_ifu_pf: instruction prefetcher, one outstanding doubleword fetch feeding a FWFT buffer
module ysyx_22050710_ifu_pf
  import ysyx_22050710_ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic [XLEN-1:0]   o_mem_req_addr,
  input  logic              i_mem_rsp_valid,
  input  logic [XLEN-1:0]   i_mem_rsp_data,
  input  logic              i_redirect_valid,
  input  logic [XLEN-1:0]   i_redirect_pc,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [INST_W-1:0] o_inst,
  output logic [XLEN-1:0]   o_inst_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [1:0] rst_sync_q;
  logic rst_n, room, hs, rsp_hi;
  pf_state_e state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [1:0] push_n;
  logic [CW-1:0] count;
  inst_ent_t push_d0, push_d1, head;
  // Assert asynchronously, release two edges after i_rst_n rises
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) rst_sync_q <= '0;
    else rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n = rst_sync_q[1];
  assign room = count <= CW'(FIFO_DEPTH - 2);
  assign hs = o_mem_req_valid & i_mem_req_ready;
  assign rsp_hi = fpc_q[2];
  assign push_d0 = {rsp_hi ? i_mem_rsp_data[63:32] : i_mem_rsp_data[31:0], fpc_q};
  assign push_d1 = {i_mem_rsp_data[63:32], fpc_q + 64'd4};
  always_comb begin
    state_d = state_q;
    fpc_d = fpc_q;
    push_n = 2'd0;
    case (state_q)
      IDLE: state_d = (room && !i_redirect_valid) ? REQ : IDLE;
      REQ: state_d = hs ? (i_redirect_valid ? DISCARD : WAIT) : (i_redirect_valid ? IDLE : REQ);
      WAIT:
        if (i_mem_rsp_valid) begin
          state_d = IDLE;
          if (!i_redirect_valid) begin
            push_n = rsp_hi ? 2'd1 : 2'd2;
            fpc_d = fpc_q + (rsp_hi ? 64'd4 : 64'd8);
          end
        end else if (i_redirect_valid) state_d = DISCARD;
      DISCARD: state_d = i_mem_rsp_valid ? IDLE : DISCARD;
      default: state_d = IDLE;
    endcase
    if (i_redirect_valid) fpc_d = i_redirect_pc & ~64'd3;
  end
  always_ff @(posedge i_clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      fpc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      fpc_q <= fpc_d;
    end
  ysyx_22050710_ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(i_clk),
    .rst_n(rst_n),
    .flush(i_redirect_valid),
    .push_n(push_n),
    .push_d0(push_d0),
    .push_d1(push_d1),
    .pop(o_inst_valid & i_inst_ready),
    .valid(o_inst_valid),
    .head(head),
    .count(count)
  );
  assign o_mem_req_valid = state_q == REQ;
  assign o_mem_req_addr = {fpc_q[XLEN-1:3], 3'b000};
  assign o_inst = head.inst;
  assign o_inst_pc = head.pc;
endmodule

// File: tb/tb_ysyx_22050710_ifu_pf.sv
// tb_ysyx_22050710_ifu_pf: scoreboard bench with a behavioural memory and fetch-PC reference model
module tb_ysyx_22050710_ifu_pf;
  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } ent_t;
  logic i_clk, i_rst_n, o_mem_req_valid, i_mem_req_ready, i_mem_rsp_valid;
  logic i_redirect_valid, o_inst_valid, i_inst_ready;
  logic [63:0] o_mem_req_addr, i_mem_rsp_data, i_redirect_pc, o_inst_pc;
  logic [31:0] o_inst;
  int passed = 0, total = 0, hs_count = 0, rsp_timer = 0, rsp_lat = 1;
  logic outstanding = 0, stale = 0;
  logic [63:0] exp_pc = 64'h8000_0000, last_addr = '0, rsp_addr = '0;
  ent_t q[$];

  ysyx_22050710_ifu_pf dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready), .o_mem_req_addr(o_mem_req_addr),
    .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_data(i_mem_rsp_data),
    .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
    .o_inst_valid(o_inst_valid), .i_inst_ready(i_inst_ready), .o_inst(o_inst), .o_inst_pc(o_inst_pc)
  );

  initial i_clk = 0;
  always #5 i_clk = ~i_clk;
  initial begin
    #300000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return a == 64'h8000_0000 ? 64'h00000013_00100093 : {a[31:0] ^ 32'h1357_9BDF, a[31:0] ^ 32'h2468_ACE0};
  endfunction

  task automatic model_reset();
    q.delete();
    exp_pc = 64'h8000_0000;
    outstanding = 0;
    stale = 0;
  endtask

  task automatic step();
    logic hs, pp;
    ent_t e;
    logic [63:0] d;
    #1;
    hs = i_rst_n && o_mem_req_valid && i_mem_req_ready;
    pp = i_rst_n && o_inst_valid && i_inst_ready;
    if (pp) begin
      total++;
      if (q.size() == 0) $display("FAIL pop_unexpected inst=%h pc=%h required no entry", o_inst, o_inst_pc);
      else begin
        e = q.pop_front();
        if (o_inst !== e.inst || o_inst_pc !== e.pc)
          $display("FAIL pop inst=%h pc=%h required inst=%h pc=%h", o_inst, o_inst_pc, e.inst, e.pc);
        else passed++;
      end
    end
    if (hs) begin
      total++;
      if (o_mem_req_addr !== {exp_pc[63:3], 3'b000} || outstanding)
        $display("FAIL req_addr addr=%h outstanding=%0d required addr=%h outstanding=0", o_mem_req_addr, outstanding, {exp_pc[63:3], 3'b000});
      else passed++;
      last_addr = o_mem_req_addr;
      hs_count++;
    end
    if (i_mem_rsp_valid && outstanding) begin
      d = i_mem_rsp_data;
      if (!stale && !i_redirect_valid) begin
        if (!exp_pc[2]) begin
          q.push_back({d[31:0], exp_pc});
          q.push_back({d[63:32], exp_pc + 64'd4});
          exp_pc = exp_pc + 64'd8;
        end else begin
          q.push_back({d[63:32], exp_pc});
          exp_pc = exp_pc + 64'd4;
        end
      end
      outstanding = 0;
      stale = 0;
    end
    if (hs) begin
      outstanding = 1;
      stale = i_redirect_valid;
      rsp_timer = rsp_lat;
      rsp_addr = o_mem_req_addr;
    end
    if (i_rst_n && i_redirect_valid) begin
      q.delete();
      exp_pc = {i_redirect_pc[63:2], 2'b00};
      if (outstanding) stale = 1;
    end
    @(posedge i_clk);
    #1;
    i_mem_rsp_valid = 0;
    if (rsp_timer > 0) begin
      rsp_timer--;
      if (rsp_timer == 0) begin
        i_mem_rsp_valid = 1;
        i_mem_rsp_data = mem_word(rsp_addr);
      end
    end
    total++;
    if (o_inst_valid !== (q.size() != 0))
      $display("FAIL inst_valid valid=%b required %b", o_inst_valid, q.size() != 0);
    else passed++;
  endtask

  task automatic do_reset();
    i_rst_n = 0;
    i_mem_req_ready = 0;
    i_mem_rsp_valid = 0;
    i_redirect_valid = 0;
    i_inst_ready = 0;
    rsp_timer = 0;
    rsp_lat = 1;
    model_reset();
    repeat (3) step();
    i_rst_n = 1;
  endtask

  task automatic test_reset();
    i_rst_n = 1;
    i_mem_req_ready = 1;
    i_mem_rsp_valid = 0;
    i_mem_rsp_data = '0;
    i_redirect_valid = 0;
    i_redirect_pc = '0;
    i_inst_ready = 0;
    #2;
    i_rst_n = 0;
    #1;
    total++;
    if ({o_mem_req_valid, o_inst_valid, o_inst, o_inst_pc} !== '0)
      $display("FAIL reset_outputs req=%b valid=%b inst=%h pc=%h required all zero", o_mem_req_valid, o_inst_valid, o_inst, o_inst_pc);
    else passed++;
    do_reset();
    i_mem_req_ready = 1;
    step();
    total++;
    if (o_mem_req_valid !== 1'b0) $display("FAIL early_req req=%b required 0", o_mem_req_valid);
    else passed++;
    for (int i = 0; i < 10 && !o_mem_req_valid; i++) step();
    total++;
    if (o_mem_req_valid !== 1'b1 || o_mem_req_addr !== 64'h8000_0000)
      $display("FAIL first_req req=%b addr=%h required 1 addr=80000000", o_mem_req_valid, o_mem_req_addr);
    else passed++;
  endtask

  task automatic test_basic();
    do_reset();
    i_mem_req_ready = 1;
    for (int i = 0; i < 20 && !i_mem_rsp_valid; i++) step();
    step();
    total++;
    if (o_inst_valid !== 1'b1 || o_inst !== 32'h00100093 || o_inst_pc !== 64'h8000_0000)
      $display("FAIL basic_lo valid=%b inst=%h pc=%h required 1 00100093 80000000", o_inst_valid, o_inst, o_inst_pc);
    else passed++;
    i_inst_ready = 1;
    step();
    i_inst_ready = 0;
    total++;
    if (o_inst !== 32'h00000013 || o_inst_pc !== 64'h8000_0004)
      $display("FAIL basic_hi inst=%h pc=%h required 00000013 80000004", o_inst, o_inst_pc);
    else passed++;
  endtask

  task automatic test_fill();
    int base;
    do_reset();
    base = hs_count;
    i_mem_req_ready = 1;
    repeat (30) step();
    total++;
    if (hs_count - base !== 2 || o_mem_req_valid !== 1'b0)
      $display("FAIL fill_stop fetches=%0d req=%b required 2 fetches req=0", hs_count - base, o_mem_req_valid);
    else passed++;
    i_inst_ready = 1;
    step();
    i_inst_ready = 0;
    repeat (10) step();
    total++;
    if (hs_count - base !== 2) $display("FAIL fill_one_free fetches=%0d required 2", hs_count - base);
    else passed++;
    i_inst_ready = 1;
    step();
    i_inst_ready = 0;
    for (int i = 0; i < 10 && hs_count - base < 3; i++) step();
    total++;
    if (hs_count - base !== 3) $display("FAIL fill_resume fetches=%0d required 3", hs_count - base);
    else passed++;
  endtask

  task automatic test_redirect_req();
    int base;
    do_reset();
    i_inst_ready = 1;
    for (int i = 0; i < 10 && !o_mem_req_valid; i++) step();
    i_redirect_valid = 1;
    i_redirect_pc = 64'h8000_0104;
    step();
    i_redirect_valid = 0;
    total++;
    if (o_mem_req_valid !== 1'b0) $display("FAIL withdraw req=%b required 0", o_mem_req_valid);
    else passed++;
    step();
    total++;
    if (o_mem_req_valid !== 1'b1 || o_mem_req_addr !== 64'h8000_0100)
      $display("FAIL redir_t2 req=%b addr=%h required 1 addr=80000100", o_mem_req_valid, o_mem_req_addr);
    else passed++;
    base = hs_count;
    i_mem_req_ready = 1;
    for (int i = 0; i < 10 && !o_inst_valid; i++) step();
    total++;
    if (o_inst_valid !== 1'b1 || o_inst_pc !== 64'h8000_0104)
      $display("FAIL redir_hi_pc valid=%b pc=%h required 1 pc=80000104", o_inst_valid, o_inst_pc);
    else passed++;
    for (int i = 0; i < 10 && hs_count - base < 2; i++) step();
    total++;
    if (hs_count - base !== 2 || last_addr !== 64'h8000_0108)
      $display("FAIL redir_next fetches=%0d addr=%h required 2 addr=80000108", hs_count - base, last_addr);
    else passed++;
  endtask

  task automatic test_redirect_wait();
    int base;
    do_reset();
    rsp_lat = 3;
    i_mem_req_ready = 1;
    base = hs_count;
    for (int i = 0; i < 10 && hs_count == base; i++) step();
    i_redirect_valid = 1;
    i_redirect_pc = 64'h8000_1000;
    step();
    i_redirect_valid = 0;
    for (int i = 0; i < 20 && hs_count - base < 2; i++) step();
    total++;
    if (hs_count - base !== 2 || last_addr !== 64'h8000_1000 || o_inst_valid !== 1'b0)
      $display("FAIL wait_redir fetches=%0d addr=%h valid=%b required 2 addr=80001000 valid=0", hs_count - base, last_addr, o_inst_valid);
    else passed++;
  endtask

  task automatic test_redirect_corner();
    int base;
    do_reset();
    i_mem_req_ready = 1;
    i_inst_ready = 1;
    for (int i = 0; i < 10 && !o_mem_req_valid; i++) step();
    base = hs_count;
    i_redirect_valid = 1;
    i_redirect_pc = 64'h8000_2008;
    step();
    i_redirect_valid = 0;
    total++;
    if (hs_count - base !== 1 || o_mem_req_valid !== 1'b0)
      $display("FAIL hs_redir fetches=%0d req=%b required 1 req=0", hs_count - base, o_mem_req_valid);
    else passed++;
    for (int i = 0; i < 10 && hs_count - base < 2; i++) step();
    total++;
    if (last_addr !== 64'h8000_2008) $display("FAIL discard_next addr=%h required 80002008", last_addr);
    else passed++;
    i_redirect_valid = 1;
    i_redirect_pc = 64'h8000_3000;
    step();
    i_redirect_valid = 0;
    total++;
    if (o_inst_valid !== 1'b0 || i_mem_rsp_valid !== 1'b0)
      $display("FAIL rsp_redir valid=%b rsp=%b required 0 0", o_inst_valid, i_mem_rsp_valid);
    else passed++;
    for (int i = 0; i < 10 && hs_count - base < 3; i++) step();
    total++;
    if (last_addr !== 64'h8000_3000) $display("FAIL rsp_redir_next addr=%h required 80003000", last_addr);
    else passed++;
  endtask

  task automatic test_wrap();
    int base;
    do_reset();
    i_inst_ready = 1;
    for (int i = 0; i < 10 && !o_mem_req_valid; i++) step();
    i_redirect_valid = 1;
    i_redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    step();
    i_redirect_valid = 0;
    i_mem_req_ready = 1;
    base = hs_count;
    for (int i = 0; i < 20 && !o_inst_valid; i++) step();
    total++;
    if (o_inst_pc !== 64'hFFFF_FFFF_FFFF_FFF8) $display("FAIL wrap_pc pc=%h required fffffffffffffff8", o_inst_pc);
    else passed++;
    for (int i = 0; i < 20 && hs_count - base < 2; i++) step();
    total++;
    if (hs_count - base !== 2 || last_addr !== 64'h0)
      $display("FAIL wrap_addr fetches=%0d addr=%h required 2 addr=0", hs_count - base, last_addr);
    else passed++;
  endtask

  task automatic test_reset_wait();
    int base;
    do_reset();
    rsp_lat = 3;
    i_mem_req_ready = 1;
    base = hs_count;
    for (int i = 0; i < 10 && hs_count == base; i++) step();
    i_rst_n = 0;
    #1;
    total++;
    if ({o_mem_req_valid, o_inst_valid, o_inst, o_inst_pc} !== '0)
      $display("FAIL wait_reset req=%b valid=%b inst=%h pc=%h required all zero", o_mem_req_valid, o_inst_valid, o_inst, o_inst_pc);
    else passed++;
    model_reset();
    i_mem_req_ready = 0;
    #1;
    i_rst_n = 1;
    repeat (6) step();
    total++;
    if (o_inst_valid !== 1'b0 || o_mem_req_valid !== 1'b1 || o_mem_req_addr !== 64'h8000_0000)
      $display("FAIL late_rsp valid=%b req=%b addr=%h required 0 1 80000000", o_inst_valid, o_mem_req_valid, o_mem_req_addr);
    else passed++;
    i_mem_req_ready = 1;
    for (int i = 0; i < 20 && !o_inst_valid; i++) step();
    total++;
    if (o_inst !== 32'h00100093 || o_inst_pc !== 64'h8000_0000)
      $display("FAIL restart inst=%h pc=%h required 00100093 80000000", o_inst, o_inst_pc);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      i_inst_ready = $urandom_range(0, 1) == 1;
      i_mem_req_ready = $urandom_range(0, 3) != 0;
      rsp_lat = $urandom_range(1, 3);
      i_redirect_valid = $urandom_range(0, 15) == 0;
      i_redirect_pc = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 4 + 64'($urandom_range(0, 3));
      step();
    end
    i_redirect_valid = 0;
    i_mem_req_ready = 0;
    i_inst_ready = 1;
    repeat (20) step();
    total++;
    if (o_inst_valid !== 1'b0 || q.size() != 0)
      $display("FAIL drain valid=%b left=%0d required 0 0", o_inst_valid, q.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_redirect_req();
    test_redirect_wait();
    test_redirect_corner();
    test_wrap();
    test_reset_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ysyx_22050710_ifu_pf.md
YSYX_22050710_IFU_PF -- requirements
Module: ysyx_22050710_ifu_pf

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h8000_0000, first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, instruction-buffer entries; power of two, >=2.
REQ-003 SHALL have i_clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have i_rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have o_mem_req_valid, output, 1, fetch request valid.
REQ-006 SHALL have i_mem_req_ready, input, 1, memory accepts request.
REQ-007 SHALL have o_mem_req_addr, output, 64, 8-byte-aligned fetch address.
REQ-008 SHALL have i_mem_rsp_valid, input, 1, response data valid.
REQ-009 SHALL have i_mem_rsp_data, input, 64, fetched doubleword.
REQ-010 SHALL have i_redirect_valid, input, 1, branch/trap redirect.
REQ-011 SHALL have i_redirect_pc, input, 64, redirect target.
REQ-012 SHALL have o_inst_valid, output, 1, buffer head valid.
REQ-013 SHALL have i_inst_ready, input, 1, decode accepts head.
REQ-014 SHALL have o_inst, output, 32, head instruction.
REQ-015 SHALL have o_inst_pc, output, 64, head instruction PC.

Function
REQ-016 Fetch PC register fpc SHALL drive o_mem_req_addr as {fpc[63:3],3'b000}.
REQ-017 FSM SHALL have states IDLE, REQ, WAIT, DISCARD; at most one request outstanding.
REQ-018 IDLE->REQ when free entries >=2 and no redirect; else hold IDLE.
REQ-019 In REQ, o_mem_req_valid=1 with address stable until handshake (valid & ready); handshake -> WAIT.
REQ-020 In WAIT, on i_mem_rsp_valid: fpc[2]=0 -> push low word (pc=fpc) then high word (pc=fpc+4), fpc+=8; fpc[2]=1 -> push high word only (pc=fpc), fpc+=4; -> IDLE.
REQ-021 Buffer SHALL be FIFO, first-word-fall-through: o_inst_valid = (count!=0), head on o_inst/o_inst_pc combinationally from storage.
REQ-022 Pop on o_inst_valid & i_inst_ready; push and pop in same cycle SHALL both take effect; count never exceeds FIFO_DEPTH (guaranteed by REQ-018).
REQ-023 Redirect in any state: fpc <= {i_redirect_pc[63:2],2'b00}; FIFO emptied next cycle; pop handshake in the same cycle still counts as consumed.
REQ-024 Redirect in REQ without handshake: request withdrawn (only legal withdrawal), -> IDLE; with handshake same cycle: -> DISCARD.
REQ-025 Redirect in WAIT: -> DISCARD; if i_mem_rsp_valid same cycle, data dropped, -> IDLE.
REQ-026 DISCARD: response dropped on arrival, -> IDLE; further redirects only update fpc.
REQ-027 Latency: response at cycle r -> o_inst_valid at r+1; redirect at t -> o_mem_req_valid at t+2 earliest.
REQ-028 fpc wrap-around past 2^64-8 SHALL wrap modulo 2^64 without error.

Reset
REQ-029 On i_rst_n low, asynchronously: state=IDLE, fpc=RESET_PC, FIFO count/pointers=0, o_mem_req_valid=0, o_inst_valid=0, o_inst=0, o_inst_pc=0 (when empty).
REQ-030 Reset asserted mid-request SHALL abandon it; any later response while IDLE SHALL be ignored.
REQ-031 Deassertion SHALL be synchronised by the top-level; first request no earlier than first edge after release.

Structure
REQ-032 Shared package ysyx_22050710_ifu_pkg SHALL hold state enum, XLEN=64, INST_W=32, default RESET_PC.
REQ-033 FIFO SHALL be sub-module ysyx_22050710_ifu_fifo: parametrised depth, push of 0/1/2 entries, single pop, synchronous flush.

Verification
REQ-034 Reset release, memory ready=1, rsp one cycle after accept with 64'h00000013_00100093 -> addr 0x80000000, outputs 0x00100093@0x80000000 then 0x00000013@0x80000004.
REQ-035 Redirect to 0x80000104 -> request addr 0x80000100, only high word pushed, pc 0x80000104, next request 0x80000108.
REQ-036 i_inst_ready=0, FIFO_DEPTH=4 -> two fetches fill buffer, no third request until a pop frees 2 entries.
REQ-037 Redirect during WAIT to 0x80001000 -> stale response dropped, FIFO empty, next request 0x80001000.
REQ-038 Redirect in REQ with i_mem_req_ready=0 -> valid drops next cycle, new address presented at t+2.
REQ-039 i_rst_n low while in WAIT -> all outputs zero immediately; late response ignored; fetch restarts at RESET_PC.
